// File: rtl/fft_pkg.sv
// Shared FFT constants and helpers, used by the stage modules and the output reorder buffer.
package fft_pkg;
  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 17;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store: synchronous write, asynchronous read (parent registers the read data).
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic             wbank_i,
  input  logic [LOG2N-1:0] waddr_i,
  input  cplx_t            wdata_i,
  input  logic             rbank_i,
  input  logic [LOG2N-1:0] raddr_i,
  output cplx_t            rdata_o
);
  cplx_t mem_q [0:1][0:N-1];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wbank_i][waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[rbank_i][raddr_i];
endmodule

// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 32-point FFT output, ping-pong banked.
module fft_reorder
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] data_in_r,
  input  logic signed [DW-1:0] data_in_i,
  output logic                 valid_o,
  output logic signed [DW-1:0] data_out_r,
  output logic signed [DW-1:0] data_out_i,
  output logic [LOG2N-1:0]     bin_o,
  output logic                 sop_o,
  output logic                 eop_o
);
  logic             valid_q;
  cplx_t            din_q, din_d;
  logic [LOG2N-1:0] k_q, k_d;
  logic             wb_q, wb_d;
  logic [1:0]       full_q, full_d;
  logic [LOG2N-1:0] ra_q, ra_d;
  logic             rb_q, rb_d;
  rd_state_e        state_q, state_d;

  cplx_t            out_q, out_d;
  logic             vld_o_q, vld_o_d;
  logic [LOG2N-1:0] bin_q, bin_d;
  logic             sop_q, sop_d, eop_q, eop_d;

  cplx_t            rdata;
  logic             wr_done;
  logic             rd_go;

  assign din_d   = '{re: data_in_r, im: data_in_i};
  assign wr_done = valid_q && (k_q == 5'd31);
  // A filled bank is read from IDLE in the same cycle it is seen, saving a cycle of latency.
  assign rd_go   = (state_q == RD_READ) || full_q[rb_q];

  fft_pingpong_ram u_ram (
    .clk     (clk),
    .we_i    (valid_q),
    .wbank_i (wb_q),
    .waddr_i (bitrev5(k_q)),
    .wdata_i (din_q),
    .rbank_i (rb_q),
    .raddr_i (ra_q),
    .rdata_o (rdata)
  );

  always_comb begin
    k_d     = k_q;
    wb_d    = wb_q;
    full_d  = full_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    state_d = state_q;
    out_d   = out_q;
    bin_d   = bin_q;
    vld_o_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;

    if (rd_go) begin
      out_d   = rdata;
      bin_d   = ra_q;
      vld_o_d = 1'b1;
      sop_d   = (ra_q == 5'd0);
      eop_d   = (ra_q == 5'd31);
      ra_d    = ra_q + 5'd1;
      state_d = RD_READ;
      if (ra_q == 5'd31) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        // Chain straight into the other bank if it is ready or completes this cycle.
        if (full_q[~rb_q] || (wr_done && (wb_q == ~rb_q))) state_d = RD_READ;
        else                                               state_d = RD_IDLE;
      end
    end

    if (valid_q) begin
      k_d = k_q + 5'd1;
      if (wr_done) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      din_q   <= '0;
      k_q     <= '0;
      wb_q    <= 1'b0;
      full_q  <= '0;
      ra_q    <= '0;
      rb_q    <= 1'b0;
      state_q <= RD_IDLE;
      out_q   <= '0;
      vld_o_q <= 1'b0;
      bin_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      valid_q <= valid_i;
      din_q   <= din_d;
      k_q     <= k_d;
      wb_q    <= wb_d;
      full_q  <= full_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      state_q <= state_d;
      out_q   <= out_d;
      vld_o_q <= vld_o_d;
      bin_q   <= bin_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign valid_o    = vld_o_q;
  assign data_out_r = out_q.re;
  assign data_out_i = out_q.im;
  assign bin_o      = bin_q;
  assign sop_o      = sop_q;
  assign eop_o      = eop_q;
endmodule
